quad_step_gen: RTL and testbench
================================

Name: quad_step_gen

Overview:
- Quadrature waveform generator. It is the transmit-side counterpart to the rotary-encoder decoder.
- It converts single-cycle step commands (increment or decrement) into detent-style A/B quadrature sequences. Phase timing is set so that the decoder samples every phase at least 3 times.
- Uses: as an on-board encoder emulator for closed-loop board self-test, and to drive downstream quadrature inputs.
- Requests arriving during a step are buffered in a signed pending counter.

Parameters:
- CLK_DIV, 125_000, clk cycles per phase tick (1 kHz at 125 MHz); minimum 2.
- PHASE_TICKS, 4, ticks each output phase is held; minimum 1.
- PEND_W, 4, width of signed pending counter; saturates at ±(2^(PEND_W-1)-1).

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- step_inc, input, 1, one-cycle request for one increment step.
- step_dec, input, 1, one-cycle request for one decrement step.
- data_a, output, 1, quadrature channel A (registered).
- data_b, output, 1, quadrature channel B (registered).
- busy, output, 1, high while a step sequence is in flight.
- dir, output, 1, direction of the in-flight step: 1 = inc, 0 = dec; holds its last value when idle.
- pending, output, PEND_W, signed net count of queued steps (positive = inc).
- step_done, output, 1, one-cycle pulse when a step sequence completes.
- ovf, output, 1, sticky flag: a request was dropped because of saturation.

Behaviour:
- Reset values: data_a=1, data_b=1, busy=0, dir=0, pending=0, step_done=0, ovf=0. Divider and phase timer are cleared and the FSM goes to IDLE.
- Reset mid-sequence aborts immediately. The outputs return to 11 on the next edge and queued steps are discarded.
- Pending update, applied every cycle: next = pending + step_inc - step_dec - deq.
  - deq = +1 when an inc step is dequeued, -1 for dec, 0 otherwise.
  - step_inc and step_dec in the same cycle cancel: no change, no ovf.
  - Saturation applies to requests only. A request that would push |pending| past the limit is dropped and sets ovf.
  - A dequeue in the same cycle is applied first, so a request made while full but dequeuing is accepted.
  - An opposite-direction request reduces the magnitude of pending. It never alters the in-flight step.
- Divider:
  - Counts 0..CLK_DIV-1 only while busy; tick is asserted at CLK_DIV-1.
  - Cleared on entry to PH1.
  - Each phase lasts exactly PHASE_TICKS*CLK_DIV cycles.
- FSM states, with the (A,B) value held in each:
  - IDLE (11): if pending≠0, latch dir = (pending>0), dequeue one step, go to PH1, set busy=1.
  - PH1: 01 for inc, 10 for dec.
  - PH2: 00.
  - PH3: 10 for inc, 01 for dec.
  - GAP (11): guard interval so the decoder re-arms.
  - Each of PH1, PH2, PH3 and GAP advances to the next state after PHASE_TICKS ticks: PH1→PH2→PH3→GAP→IDLE.
- Step completion (GAP exits):
  - step_done=1 for one cycle.
  - If pending≠0, go directly to PH1 of the next step: latch dir, dequeue, clear divider, busy stays 1. The step_done pulse is still emitted.
  - Otherwise go to IDLE and busy=0.
- Latency: with idle FSM and pending=0, a request in cycle N gives pending≠0 at N+1. data_a/data_b show the PH1 value at N+2.
- Full step length: 4*PHASE_TICKS*CLK_DIV cycles.
- Exactly one output bit changes per phase transition (Gray sequence). A and B never change in the same cycle.
- Arithmetic on pending is PEND_W-bit two's complement. The output is the raw register value.

Test Plan (CLK_DIV=4, PHASE_TICKS=2, PEND_W=4 unless noted):
- Single step_inc pulse at cycle 10:
  - (A,B)=01 from cycle 12 for 8 cycles, then 00 ×8, 10 ×8, 11 ×8.
  - step_done pulses at cycle 44; busy falls at 44/45; pending returns to 0.
- Single step_dec: sequence 10, 00, 01, 11 with the same timing; dir=0 throughout.
- Three step_inc pulses 1 cycle apart:
  - pending peaks at 2 (one step dequeued immediately).
  - Three back-to-back inc sequences with no IDLE gap; busy stays high for 96 cycles; 3 step_done pulses.
- step_inc and step_dec asserted in the same cycle while idle: pending stays 0, no sequence, ovf=0.
- Saturation, with one step in flight: issue 9 step_inc pulses.
  - pending saturates at 7; the 8th and 9th requests are dropped; ovf=1 and stays set.
  - Then 2 step_dec pulses bring pending to 5.
- rst asserted during PH2 of an inc step with pending=3: next edge gives A,B=11, busy=0, pending=0, ovf=0, no step_done. A new step_inc starts a normal sequence.
- Closed-loop check: output fed to the rotary-encoder decoder (default params). N inc requests produce exactly N pul_inc and 0 pul_dec; the same holds for dec.

Source files
------------

// File: rtl/quad_step_gen.sv
// Quadrature step generator: turns single-cycle inc/dec step requests into
// detent-style A/B sequences (11 -> 01 -> 00 -> 10 -> 11 for inc), queueing bursts in a signed counter.
module quad_step_gen #(
  parameter int CLK_DIV     = 125_000,
  parameter int PHASE_TICKS = 4,
  parameter int PEND_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step_inc,
  input  logic              step_dec,
  output logic              data_a,
  output logic              data_b,
  output logic              busy,
  output logic              dir,
  output logic [PEND_W-1:0] pending,
  output logic              step_done,
  output logic              ovf
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PT_W  = (PHASE_TICKS > 1) ? $clog2(PHASE_TICKS) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [PT_W-1:0]   PT_LAST   = PT_W'(PHASE_TICKS - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = {1'b0, {(PEND_W-1){1'b1}}};
  localparam logic [PEND_W-1:0] PEND_MIN  = ~PEND_MAX + PEND_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PH1,
    S_PH2,
    S_PH3,
    S_GAP
  } state_t;

  state_t            state_q, state_d;
  logic              dir_q, dir_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [PT_W-1:0]   ptick_q, ptick_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              data_a_q, data_a_d;
  logic              data_b_q, data_b_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              tick;
  logic              phase_end;
  logic              start;
  logic              deq_inc;
  logic              deq_dec;
  logic [PEND_W-1:0] pend_base;

  assign tick      = (state_q != S_IDLE) && (div_q == DIV_LAST);
  assign phase_end = tick && (ptick_q == PT_LAST);

  // A new step launches from IDLE, or straight out of GAP when more work is queued.
  assign start = (pend_q != '0) &&
                 ((state_q == S_IDLE) || ((state_q == S_GAP) && phase_end));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    deq_inc = 1'b0;
    deq_dec = 1'b0;
    case (state_q)
      S_IDLE:  if (start) state_d = S_PH1;
      S_PH1:   if (phase_end) state_d = S_PH2;
      S_PH2:   if (phase_end) state_d = S_PH3;
      S_PH3:   if (phase_end) state_d = S_GAP;
      S_GAP:   if (phase_end) state_d = start ? S_PH1 : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (start) begin
      dir_d   = ~pend_q[PEND_W-1];
      deq_inc = ~pend_q[PEND_W-1];
      deq_dec = pend_q[PEND_W-1];
    end
  end

  // Phase timing: the divider produces ticks, ptick counts ticks within a phase.
  always_comb begin
    div_d   = div_q;
    ptick_d = ptick_q;
    if (start || (state_d == S_IDLE)) begin
      div_d   = '0;
      ptick_d = '0;
    end else if (tick) begin
      div_d   = '0;
      ptick_d = phase_end ? '0 : ptick_q + PT_W'(1);
    end else begin
      div_d   = div_q + DIV_W'(1);
    end
  end

  // Dequeue is applied before the request so a full counter can still accept one.
  always_comb begin
    pend_base = pend_q;
    if (deq_inc) begin
      pend_base = pend_q - PEND_W'(1);
    end else if (deq_dec) begin
      pend_base = pend_q + PEND_W'(1);
    end
    pend_d = pend_base;
    ovf_d  = ovf_q;
    if (step_inc && !step_dec) begin
      if (pend_base == PEND_MAX) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_base + PEND_W'(1);
      end
    end else if (step_dec && !step_inc) begin
      if (pend_base == PEND_MIN) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_base - PEND_W'(1);
      end
    end
  end

  // Output logic: outputs are registered from the upcoming state.
  always_comb begin
    data_a_d = 1'b1;
    data_b_d = 1'b1;
    case (state_d)
      S_PH1: begin
        data_a_d = ~dir_d;
        data_b_d = dir_d;
      end
      S_PH2: begin
        data_a_d = 1'b0;
        data_b_d = 1'b0;
      end
      S_PH3: begin
        data_a_d = dir_d;
        data_b_d = ~dir_d;
      end
      default: begin
        data_a_d = 1'b1;
        data_b_d = 1'b1;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_GAP) && phase_end;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= '0;
      ptick_q  <= '0;
      pend_q   <= '0;
      ovf_q    <= 1'b0;
      data_a_q <= 1'b1;
      data_b_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      div_q    <= div_d;
      ptick_q  <= ptick_d;
      pend_q   <= pend_d;
      ovf_q    <= ovf_d;
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign data_a    = data_a_q;
  assign data_b    = data_b_q;
  assign busy      = busy_q;
  assign dir       = dir_q;
  assign pending   = pend_q;
  assign step_done = done_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_quad_step_gen.sv
// Self-checking bench for quad_step_gen: directed scenarios plus a randomized
// run against a step-timeline reference model and an A/B detent decoder.
module tb_quad_step_gen;

  localparam int CLK_DIV     = 4;
  localparam int PHASE_TICKS = 2;
  localparam int PEND_W      = 4;
  localparam int PH          = CLK_DIV * PHASE_TICKS;
  localparam int STEP        = 4 * PH;
  localparam int PMAX        = (1 << (PEND_W - 1)) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              step_inc;
  logic              step_dec;
  logic              data_a;
  logic              data_b;
  logic              busy;
  logic              dir;
  logic [PEND_W-1:0] pending;
  logic              step_done;
  logic              ovf;

  quad_step_gen #(
    .CLK_DIV    (CLK_DIV),
    .PHASE_TICKS(PHASE_TICKS),
    .PEND_W     (PEND_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .step_inc (step_inc),
    .step_dec (step_dec),
    .data_a   (data_a),
    .data_b   (data_b),
    .busy     (busy),
    .dir      (dir),
    .pending  (pending),
    .step_done(step_done),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: a step is a 4*PH cycle timeline indexed by m_t.
  int m_pend = 0;
  int m_t    = 0;
  bit m_act  = 1'b0;
  bit m_dir  = 1'b0;
  bit m_done = 1'b0;
  bit m_ovf  = 1'b0;

  // Decoder / Gray monitor state
  logic prev_a = 1'b1;
  logic prev_b = 1'b1;
  int   gray_viol = 0;
  int   dec_inc   = 0;
  int   dec_dec   = 0;

  function automatic logic [1:0] exp_ab();
    if (!m_act) return 2'b11;
    case (m_t / PH)
      0:       return m_dir ? 2'b01 : 2'b10;
      1:       return 2'b00;
      2:       return m_dir ? 2'b10 : 2'b01;
      default: return 2'b11;
    endcase
  endfunction

  task automatic model_step(input bit inc, input bit dec, input bit r);
    int deq;
    int p;
    if (r) begin
      m_pend = 0; m_t = 0; m_act = 0; m_dir = 0; m_done = 0; m_ovf = 0;
    end else begin
      deq    = 0;
      m_done = 0;
      if (m_act) begin
        m_t++;
        if (m_t == STEP) begin
          m_done = 1;
          if (m_pend != 0) begin
            m_dir = (m_pend > 0);
            deq   = m_dir ? 1 : -1;
            m_t   = 0;
          end else begin
            m_act = 0;
            m_t   = 0;
          end
        end
      end else if (m_pend != 0) begin
        m_act = 1;
        m_dir = (m_pend > 0);
        deq   = m_dir ? 1 : -1;
        m_t   = 0;
      end
      p = m_pend - deq;
      if (inc && !dec) begin
        if (p == PMAX) m_ovf = 1; else p++;
      end else if (dec && !inc) begin
        if (p == -PMAX) m_ovf = 1; else p--;
      end
      m_pend = p;
    end
  endtask

  // One clock cycle: apply inputs, let the edge happen, advance model and monitor.
  task automatic drive(input bit inc, input bit dec, input bit r);
    @(negedge clk);
    step_inc = inc;
    step_dec = dec;
    rst      = r;
    @(posedge clk);
    #1;
    cyc++;
    model_step(inc, dec, r);
    if (!r) begin
      if (data_a != prev_a && data_b != prev_b) gray_viol++;
      if ({data_a, data_b} == 2'b11 && {prev_a, prev_b} == 2'b10) dec_inc++;
      if ({data_a, data_b} == 2'b11 && {prev_a, prev_b} == 2'b01) dec_dec++;
    end
    prev_a = data_a;
    prev_b = data_b;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while ((busy !== 1'b0 || pending !== '0) && n < budget) begin
      drive(0, 0, 0);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_timeout busy=%b pending=%0d required idle within %0d cycles", name, busy, pending, budget);
    end
  endtask

  task automatic test_reset();
    drive(0, 0, 1);
    drive(0, 0, 1);
    checks += 6;
    if ({data_a, data_b} !== 2'b11) begin errors++; $display("FAIL reset_ab got=%b exp=11", {data_a, data_b}); end
    if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (dir !== 1'b0)       begin errors++; $display("FAIL reset_dir got=%b exp=0", dir); end
    if (pending !== '0)     begin errors++; $display("FAIL reset_pending got=%0d exp=0", pending); end
    if (step_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", step_done); end
    if (ovf !== 1'b0)       begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    drive(0, 0, 0);
    $display("test_reset: done at cycle %0d", cyc);
  endtask

  // Request in cycle 0 -> PH1 from cycle 2, done pulse at 2+STEP.
  task automatic test_single(input bit is_inc);
    logic [1:0] e_ab;
    int ph;
    drive(0, 0, 1);
    for (int i = 0; i < 5; i++) drive(0, 0, 0);
    drive(is_inc, !is_inc, 0);
    for (int r = 1; r <= STEP + 4; r++) begin
      e_ab = 2'b11;
      if (r >= 2 && r < 2 + STEP) begin
        ph = (r - 2) / PH;
        if (ph == 0)      e_ab = is_inc ? 2'b01 : 2'b10;
        else if (ph == 1) e_ab = 2'b00;
        else if (ph == 2) e_ab = is_inc ? 2'b10 : 2'b01;
      end
      checks += 4;
      if ({data_a, data_b} !== e_ab) begin
        errors++; $display("FAIL single_ab inc=%0b r=%0d got=%b exp=%b", is_inc, r, {data_a, data_b}, e_ab);
      end
      if (busy !== (r >= 2 && r < 2 + STEP)) begin
        errors++; $display("FAIL single_busy inc=%0b r=%0d got=%b", is_inc, r, busy);
      end
      if (step_done !== (r == 2 + STEP)) begin
        errors++; $display("FAIL single_done inc=%0b r=%0d got=%b", is_inc, r, step_done);
      end
      if (pending !== ((r == 1) ? (is_inc ? 4'd1 : 4'hF) : 4'd0)) begin
        errors++; $display("FAIL single_pending inc=%0b r=%0d got=%0d", is_inc, r, pending);
      end
      if (r >= 2) begin
        checks++;
        if (dir !== is_inc) begin errors++; $display("FAIL single_dir r=%0d got=%b exp=%b", r, dir, is_inc); end
      end
      drive(0, 0, 0);
    end
    $display("test_single(inc=%0b): done at cycle %0d", is_inc, cyc);
  endtask

  task automatic test_cancel();
    drive(0, 0, 1);
    drive(0, 0, 0);
    drive(1, 1, 0);
    for (int i = 0; i < 10; i++) begin
      checks += 3;
      if (pending !== '0) begin errors++; $display("FAIL cancel_pending got=%0d exp=0", pending); end
      if (busy !== 1'b0)  begin errors++; $display("FAIL cancel_busy got=%b exp=0", busy); end
      if (ovf !== 1'b0)   begin errors++; $display("FAIL cancel_ovf got=%b exp=0", ovf); end
      drive(0, 0, 0);
    end
    $display("test_cancel: done at cycle %0d", cyc);
  endtask

  task automatic test_back_to_back();
    int peak = 0, busy_cnt = 0, done_cnt = 0, rises = 0;
    logic last_busy = 1'b0;
    drive(0, 0, 1);
    drive(0, 0, 0);
    dec_inc = 0; dec_dec = 0;
    for (int i = 0; i < 3 * STEP + 40; i++) begin
      drive(i < 3, 0, 0);
      if ($signed(pending) > peak) peak = $signed(pending);
      if (busy) busy_cnt++;
      if (busy && !last_busy) rises++;
      if (step_done) done_cnt++;
      last_busy = busy;
    end
    checks += 5;
    if (peak != 2)            begin errors++; $display("FAIL b2b_peak got=%0d exp=2", peak); end
    if (busy_cnt != 3 * STEP) begin errors++; $display("FAIL b2b_busy_cycles got=%0d exp=%0d", busy_cnt, 3 * STEP); end
    if (rises != 1)           begin errors++; $display("FAIL b2b_busy_rises got=%0d exp=1", rises); end
    if (done_cnt != 3)        begin errors++; $display("FAIL b2b_done got=%0d exp=3", done_cnt); end
    if (dec_inc != 3 || dec_dec != 0) begin
      errors++; $display("FAIL b2b_decoder got inc=%0d dec=%0d exp inc=3 dec=0", dec_inc, dec_dec);
    end
    $display("test_back_to_back: done at cycle %0d", cyc);
  endtask

  task automatic test_saturation();
    drive(0, 0, 1);
    drive(1, 0, 0);
    drive(0, 0, 0);
    for (int i = 1; i <= 9; i++) begin
      drive(1, 0, 0);
      checks += 2;
      if (pending !== PEND_W'((i > PMAX) ? PMAX : i)) begin
        errors++; $display("FAIL sat_pending req=%0d got=%0d exp=%0d", i, pending, (i > PMAX) ? PMAX : i);
      end
      if (ovf !== (i > PMAX)) begin errors++; $display("FAIL sat_ovf req=%0d got=%b exp=%b", i, ovf, i > PMAX); end
    end
    drive(0, 1, 0);
    drive(0, 1, 0);
    checks += 3;
    if (pending !== 4'd5) begin errors++; $display("FAIL sat_dec_pending got=%0d exp=5", pending); end
    if (ovf !== 1'b1)     begin errors++; $display("FAIL sat_ovf_sticky got=%b exp=1", ovf); end
    if (busy !== 1'b1)    begin errors++; $display("FAIL sat_busy got=%b exp=1", busy); end
    $display("test_saturation: done at cycle %0d", cyc);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    drive(0, 0, 1);
    for (int i = 0; i < 4; i++) drive(1, 0, 0);
    while ({data_a, data_b} !== 2'b00 && n < 4 * PH) begin drive(0, 0, 0); n++; end
    checks += 2;
    if (n >= 4 * PH)      begin errors++; $display("FAIL rstmid_reach_ph2 got ab=%b exp=00", {data_a, data_b}); end
    if (pending !== 4'd3) begin errors++; $display("FAIL rstmid_pre_pending got=%0d exp=3", pending); end
    drive(0, 0, 1);
    checks += 5;
    if ({data_a, data_b} !== 2'b11) begin errors++; $display("FAIL rstmid_ab got=%b exp=11", {data_a, data_b}); end
    if (busy !== 1'b0)      begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    if (pending !== '0)     begin errors++; $display("FAIL rstmid_pending got=%0d exp=0", pending); end
    if (ovf !== 1'b0)       begin errors++; $display("FAIL rstmid_ovf got=%b exp=0", ovf); end
    if (step_done !== 1'b0) begin errors++; $display("FAIL rstmid_done got=%b exp=0", step_done); end
    for (int i = 0; i < 3; i++) drive(0, 0, 0);
    drive(1, 0, 0);
    drive(0, 0, 0);
    checks += 2;
    if ({data_a, data_b} !== 2'b01) begin errors++; $display("FAIL rstmid_restart_ab got=%b exp=01", {data_a, data_b}); end
    if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_restart_busy got=%b exp=1", busy); end
    wait_idle(2 * STEP, "rstmid");
    $display("test_reset_mid: done at cycle %0d", cyc);
  endtask

  task automatic test_closed_loop();
    drive(0, 0, 1);
    drive(0, 0, 0);
    dec_inc = 0; dec_dec = 0;
    for (int i = 0; i < 5; i++) begin drive(1, 0, 0); drive(0, 0, 0); drive(0, 0, 0); end
    wait_idle(8 * STEP, "loop_inc");
    checks++;
    if (dec_inc != 5 || dec_dec != 0) begin
      errors++; $display("FAIL loop_inc got inc=%0d dec=%0d exp inc=5 dec=0", dec_inc, dec_dec);
    end
    dec_inc = 0; dec_dec = 0;
    for (int i = 0; i < 4; i++) begin drive(0, 1, 0); drive(0, 0, 0); end
    wait_idle(8 * STEP, "loop_dec");
    checks++;
    if (dec_inc != 0 || dec_dec != 4) begin
      errors++; $display("FAIL loop_dec got inc=%0d dec=%0d exp inc=0 dec=4", dec_inc, dec_dec);
    end
    $display("test_closed_loop: done at cycle %0d", cyc);
  endtask

  task automatic test_random();
    bit inc, dec, r;
    int inc_pct;
    drive(0, 0, 1);
    for (int i = 0; i < 4000; i++) begin
      inc_pct = (i < 2000) ? 20 : 4;
      inc = ($urandom_range(0, 99) < inc_pct);
      dec = ($urandom_range(0, 99) < ((i < 2000) ? 4 : 20));
      r   = ($urandom_range(0, 1499) == 0);
      drive(inc, dec, r);
      checks += 6;
      if ({data_a, data_b} !== exp_ab()) begin
        errors++; $display("FAIL rand_ab cyc=%0d got=%b exp=%b", cyc, {data_a, data_b}, exp_ab());
      end
      if (busy !== m_act) begin errors++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", cyc, busy, m_act); end
      if (dir !== m_dir)  begin errors++; $display("FAIL rand_dir cyc=%0d got=%b exp=%b", cyc, dir, m_dir); end
      if (pending !== PEND_W'(m_pend)) begin
        errors++; $display("FAIL rand_pending cyc=%0d got=%0d exp=%0d", cyc, $signed(pending), m_pend);
      end
      if (step_done !== m_done) begin errors++; $display("FAIL rand_done cyc=%0d got=%b exp=%b", cyc, step_done, m_done); end
      if (ovf !== m_ovf) begin errors++; $display("FAIL rand_ovf cyc=%0d got=%b exp=%b", cyc, ovf, m_ovf); end
    end
    checks++;
    if (gray_viol != 0) begin errors++; $display("FAIL gray_violations got=%0d exp=0", gray_viol); end
    $display("test_random: done at cycle %0d", cyc);
  endtask

  initial begin
    rst      = 1'b1;
    step_inc = 1'b0;
    step_dec = 1'b0;
    test_reset();
    test_single(1'b1);
    test_single(1'b0);
    test_cancel();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    test_closed_loop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
